mp_queue: RTL
=============

MP_QUEUE -- requirements
Module: mp_queue

Interface
REQ-001 Parameter D_WIDTH, default 32: entry width in bits.
REQ-002 Parameter DEPTH, default 16: entry count; SHALL be a power of two and >= 2*PORTS.
REQ-003 Parameter PORTS, default 2: enqueue/dequeue lanes per cycle; SHALL be >= 1.
REQ-004 Local ADDR_WIDTH = $clog2(DEPTH); CNT_WIDTH = ADDR_WIDTH+1.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  discard all contents (mispredict recovery).
REQ-008 w_en  in  PORTS  per-lane enqueue request.
REQ-009 w_data  in  PORTS x D_WIDTH  enqueue data; lane 0 is oldest.
REQ-010 w_ack  out  PORTS  lane accepted this cycle (combinational).
REQ-011 r_en  in  PORTS  per-lane dequeue request.
REQ-012 r_valid  out  PORTS  lane i holds a valid entry.
REQ-013 r_data  out  PORTS x D_WIDTH  lane i = entry at read pointer + i (first-word-fall-through).
REQ-014 count  out  CNT_WIDTH  current occupancy, 0..DEPTH.
REQ-015 full_sig / empty_sig  out  1 each  count==DEPTH / count==0.

Function
REQ-016 Pointers SHALL be CNT_WIDTH bits (extra wrap bit); index = low ADDR_WIDTH bits; wrap modulo DEPTH.
REQ-017 Effective write request = w_en masked to the contiguous run of ones starting at lane 0; lanes above the first 0 SHALL be ignored. Same rule for r_en.
REQ-018 w_ack[i] SHALL be 1 iff effective write request includes lane i and i < (DEPTH - count), with count sampled at cycle start.
REQ-019 r_valid[i] SHALL be 1 iff i < count; a lane dequeues iff effective r_en[i] && r_valid[i].
REQ-020 Accepted writes store w_data[i] at write_ptr+i; write_ptr advances by number accepted (nw); read_ptr advances by number dequeued (nr); count' = count + nw - nr.
REQ-021 Simultaneous read and write SHALL use start-of-cycle count only; slots freed by reads are not available to writes in the same cycle; no write-to-read bypass (written data visible next cycle at earliest).
REQ-022 flush SHALL have priority: next cycle pointers = 0, count = 0; all w_en/r_en that cycle ignored and w_ack forced to 0.
REQ-023 r_data for lanes with r_valid=0 is undefined; no output other than r_data SHALL be X after reset.
REQ-024 Latency: an entry accepted in cycle n SHALL appear on r_data lane 0..PORTS-1 with r_valid=1 in cycle n+1 at earliest.

Reset
REQ-025 On rst=1 at a clk edge: read_ptr = write_ptr = 0, count = 0, empty_sig = 1, full_sig = 0, r_valid = 0; rst overrides flush and all requests; w_ack = 0 while rst=1.
REQ-026 Storage array SHALL NOT be reset; reset mid-operation discards contents identically to flush.

Structure
REQ-027 Helper functions for contiguous-prefix mask and popcount SHALL reside in shared package mp_queue_pkg; no typedefs required.
REQ-028 No sub-module; storage is a flat register array with PORTS write and PORTS read ports.

Verification (DEPTH=8, PORTS=2, D_WIDTH=32)
REQ-029 After reset, enqueue 0xA0,0xA1 (w_en=11) -> w_ack=11; next cycle count=2, r_valid=11, r_data={0xA0,0xA1}.
REQ-030 Fill from count=7 with w_en=11 -> w_ack=01, count=8, full_sig=1; further w_en=11 -> w_ack=00, count stays 8.
REQ-031 At count=8, w_en=11 and r_en=11 same cycle -> w_ack=00, two dequeued, count=6; write succeeds next cycle.
REQ-032 w_en=10 (non-contiguous) -> w_ack=00, count unchanged; r_en=10 -> nothing dequeued.
REQ-033 Run 40 cycles random 0..2 enqueue/dequeue with scoreboard -> pointer wrap, FIFO order preserved, count matches model every cycle.
REQ-034 At count=5 assert flush with w_en=11, r_en=11 -> w_ack=00, next cycle count=0, empty_sig=1, r_valid=00; repeat with rst -> identical result.

Source files
------------

// File: rtl/mp_queue_pkg.sv
// Shared helpers for the multi-port queue: lane-request masking and popcount.
// Lane vectors are handled at a fixed maximum width and cast by the caller.
package mp_queue_pkg;

   localparam int MAX_LANES  = 32;
   localparam int LANE_CNT_W = 6;

   // Keep only the unbroken run of ones that starts at lane 0.
   function automatic logic [MAX_LANES-1:0] prefix_mask(input logic [MAX_LANES-1:0] req);
      logic                 run;
      logic [MAX_LANES-1:0] m;
      run = 1'b1;
      m   = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         run  = run & req[i];
         m[i] = run;
      end
      return m;
   endfunction

   function automatic logic [LANE_CNT_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
      logic [LANE_CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         n = n + LANE_CNT_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/mp_queue.sv
// Multi-port circular queue: up to PORTS enqueues and PORTS dequeues per cycle,
// first-word-fall-through read lanes, flush for mispredict recovery.
module mp_queue
   import mp_queue_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int DEPTH   = 16,
   parameter int PORTS   = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic [PORTS-1:0]                  w_en,
   input  logic [PORTS*D_WIDTH-1:0]          w_data,
   output logic [PORTS-1:0]                  w_ack,
   input  logic [PORTS-1:0]                  r_en,
   output logic [PORTS-1:0]                  r_valid,
   output logic [PORTS*D_WIDTH-1:0]          r_data,
   output logic [$clog2(DEPTH):0]            count,
   output logic                              full_sig,
   output logic                              empty_sig
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

   logic [D_WIDTH-1:0]    mem [DEPTH];
   logic [CNT_WIDTH-1:0]  rd_ptr;
   logic [CNT_WIDTH-1:0]  wr_ptr;
   logic [CNT_WIDTH-1:0]  cnt;

   logic [PORTS-1:0]      w_eff;
   logic [PORTS-1:0]      r_eff;
   logic [PORTS-1:0]      r_do;
   logic [CNT_WIDTH-1:0]  free_slots;
   logic [CNT_WIDTH-1:0]  nw;
   logic [CNT_WIDTH-1:0]  nr;
   logic [ADDR_WIDTH-1:0] w_idx [PORTS];
   logic [ADDR_WIDTH-1:0] r_idx [PORTS];

   // Acceptance uses only the start-of-cycle occupancy, so reads never free
   // space for writes in the same cycle; reset and flush suppress all lanes.
   always_comb begin
      w_eff      = PORTS'(prefix_mask(MAX_LANES'(w_en)));
      r_eff      = PORTS'(prefix_mask(MAX_LANES'(r_en)));
      free_slots = CNT_WIDTH'(DEPTH) - cnt;
      w_ack      = '0;
      r_valid    = '0;
      r_do       = '0;
      for (int i = 0; i < PORTS; i++) begin
         w_ack[i]   = w_eff[i] && (CNT_WIDTH'(i) < free_slots) && !flush && !rst;
         r_valid[i] = CNT_WIDTH'(i) < cnt;
         r_do[i]    = r_eff[i] && r_valid[i] && !flush && !rst;
      end
      nw = CNT_WIDTH'(popcount(MAX_LANES'(w_ack)));
      nr = CNT_WIDTH'(popcount(MAX_LANES'(r_do)));
   end

   always_comb begin
      r_data = '0;
      for (int i = 0; i < PORTS; i++) begin
         w_idx[i] = wr_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
         r_idx[i] = rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
         r_data[i*D_WIDTH +: D_WIDTH] = mem[r_idx[i]];
      end
   end

   // Pointers carry an extra wrap bit; flush and reset both return to empty.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         wr_ptr <= wr_ptr + nw;
         rd_ptr <= rd_ptr + nr;
         cnt    <= cnt + nw - nr;
      end
   end

   // Storage is intentionally not reset; stale entries are unreachable once
   // the pointers collapse.
   always_ff @(posedge clk) begin
      for (int i = 0; i < PORTS; i++) begin
         if (w_ack[i]) begin
            mem[w_idx[i]] <= w_data[i*D_WIDTH +: D_WIDTH];
         end
      end
   end

   assign count     = cnt;
   assign full_sig  = (cnt == CNT_WIDTH'(DEPTH));
   assign empty_sig = (cnt == '0);

endmodule
